// File: rtl/fan_ctrl_pkg.sv
// Shared types, constants and the demand clamp used by the fan PWM driver.
package fan_ctrl_pkg;

  localparam int ADC_BW = 8;
  localparam logic [ADC_BW-1:0] PERIOD_MAX = ADC_BW'((1 << ADC_BW) - 1);
  localparam logic [ADC_BW-1:0] LAST_CNT   = PERIOD_MAX - 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    KICK
  } fan_state_e;

  // A negative PID demand means "cool less than nothing", which a fan cannot do.
  function automatic logic [ADC_BW-1:0] clamp_duty(input logic signed [ADC_BW:0] val);
    return val[ADC_BW] ? '0 : val[ADC_BW-1:0];
  endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// Prescaler for the PWM period counter: one tick every PWM_PRESCALE clocks, held at zero while cleared.
module pwm_tick_gen #(
  parameter int PWM_PRESCALE = 4
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int PW = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PWM_PRESCALE - 1);

  logic [PW-1:0] presc_q, presc_d;

  always_comb begin
    presc_d = presc_q;
    if (clear_i || (presc_q == PRESC_LAST)) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  assign tick_o = !clear_i && (presc_q == PRESC_LAST);

endmodule

// File: rtl/pwm_fan_driver.sv
// Fan PWM driver: clamps signed PID demand to a duty and applies it only at period boundaries.
// Defining FAN_KICKSTART_EN adds a full-duty spin-up phase when the fan starts from zero duty.
module pwm_fan_driver
  import fan_ctrl_pkg::*;
#(
  parameter int ADC_BITWIDTH = ADC_BW,
  parameter int PWM_PRESCALE = 4,
  parameter int KICK_PERIODS = 16
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    enable_i,
  input  logic [ADC_BITWIDTH:0]   pid_val_i,
  output logic                    pwm_o,
  output logic                    period_strb_o,
  output logic [ADC_BITWIDTH-1:0] duty_o
);

  if (ADC_BITWIDTH != ADC_BW || PWM_PRESCALE < 1 || KICK_PERIODS < 1) begin : g_param_check
    $error("pwm_fan_driver: unsupported parameter combination");
  end

  fan_state_e              state_q, state_d;
  logic [ADC_BITWIDTH-1:0] cnt_q, cnt_d;
  logic [ADC_BITWIDTH-1:0] duty_q, duty_d;
  logic [ADC_BITWIDTH-1:0] new_duty;
  logic                    pwm_q, pwm_d;
  logic                    strb_q, strb_d;
  logic                    tick;
  logic                    boundary;
`ifdef FAN_KICKSTART_EN
  localparam int KW = $clog2(KICK_PERIODS + 1);
  logic [KW-1:0] kick_q, kick_d;
`endif

  pwm_tick_gen #(
    .PWM_PRESCALE(PWM_PRESCALE)
  ) u_tick_gen (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .clear_i(state_q == IDLE),
    .tick_o (tick)
  );

  assign new_duty = clamp_duty(pid_val_i);
  assign boundary = tick && (cnt_q == LAST_CNT);

  // Disable wins over everything, including a boundary on the same edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    duty_d  = duty_q;
    pwm_d   = 1'b0;
    strb_d  = 1'b0;
`ifdef FAN_KICKSTART_EN
    kick_d  = kick_q;
`endif
    if (!enable_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      duty_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = RUN;
          cnt_d   = '0;
          duty_d  = new_duty;
          strb_d  = 1'b1;
`ifdef FAN_KICKSTART_EN
          if (new_duty != '0) begin
            state_d = KICK;
            duty_d  = PERIOD_MAX;
            kick_d  = KW'(KICK_PERIODS);
          end
`endif
        end
        default: begin
          pwm_d = (cnt_q < duty_q);
          if (tick) begin
            cnt_d = boundary ? '0 : cnt_q + 1'b1;
          end
          if (boundary) begin
            strb_d = 1'b1;
            duty_d = new_duty;
`ifdef FAN_KICKSTART_EN
            // The kick ends early if demand drops to zero, otherwise after its last full period.
            if (state_q == KICK) begin
              if (new_duty == '0 || kick_q == KW'(1)) begin
                state_d = RUN;
              end else begin
                kick_d = kick_q - 1'b1;
                duty_d = PERIOD_MAX;
              end
            end else if (duty_q == '0 && new_duty != '0) begin
              state_d = KICK;
              duty_d  = PERIOD_MAX;
              kick_d  = KW'(KICK_PERIODS);
            end
`endif
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      duty_q  <= '0;
      pwm_q   <= 1'b0;
      strb_q  <= 1'b0;
`ifdef FAN_KICKSTART_EN
      kick_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      duty_q  <= duty_d;
      pwm_q   <= pwm_d;
      strb_q  <= strb_d;
`ifdef FAN_KICKSTART_EN
      kick_q  <= kick_d;
`endif
    end
  end

  assign pwm_o         = pwm_q;
  assign period_strb_o = strb_q;
  assign duty_o        = duty_q;

endmodule

// File: tb/tb_pwm_fan_driver.sv
// Bench for pwm_fan_driver: per-period scoreboard of duty, high time, pulse shape and strobe spacing.
module tb_pwm_fan_driver;

  localparam int ADC_BITWIDTH = 8;
  localparam int PERIOD       = 255;
  localparam int NPER         = 13;
  localparam int STROBE_LIMIT = 600;

  typedef struct {
    int duty;
    int high;
  } expT;

  logic                    clk_i    = 1'b0;
  logic                    rstn_i   = 1'b0;
  logic                    enable_i = 1'b0;
  logic [ADC_BITWIDTH:0]   pid_val_i = '0;
  logic                    pwm_o;
  logic                    period_strb_o;
  logic [ADC_BITWIDTH-1:0] duty_o;

  int  errors = 0;
  int  checks = 0;
  expT sbQ[$];

  // Demand presented during the previous period, and the duty it should produce.
  int pidTab[NPER] = '{128, 128, 200, -5, 255, 0, 50, 50, 50, 0, 50, 0, 128};
`ifdef FAN_KICKSTART_EN
  int expTab[NPER] = '{255, 255, 200, 0, 255, 0, 255, 255, 50, 0, 255, 0, 255};
  localparam int REENABLE_DUTY = 255;
`else
  int expTab[NPER] = '{128, 128, 200, 0, 255, 0, 50, 50, 50, 0, 50, 0, 128};
  localparam int REENABLE_DUTY = 60;
`endif

  pwm_fan_driver #(
    .ADC_BITWIDTH(ADC_BITWIDTH),
    .PWM_PRESCALE(1),
    .KICK_PERIODS(2)
  ) dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .enable_i     (enable_i),
    .pid_val_i    (pid_val_i),
    .pwm_o        (pwm_o),
    .period_strb_o(period_strb_o),
    .duty_o       (duty_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Inputs change 1 time unit after the sampling edge so the monitor never races them.
  task automatic applyStimulus(input logic en, input int pid);
    #1;
    enable_i  = en;
    pid_val_i = pid[ADC_BITWIDTH:0];
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic waitStrobe(input string name);
    int n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!period_strb_o && n < STROBE_LIMIT);
    if (!period_strb_o) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: no period strobe within %0d cycles", name, STROBE_LIMIT);
    end
  endtask

  task automatic pushExp(input int duty);
    expT e;
    e.duty = duty;
    e.high = duty;
    sbQ.push_back(e);
  endtask

  // Monitor: a window opens at each strobe and closes at the next, covering exactly one period of pwm_o.
  initial begin : monitor
    bit  active = 1'b0;
    bit  sawLow = 1'b0;
    bit  badShape = 1'b0;
    int  idx = 0;
    int  hiCnt = 0;
    int  dutySeen = 0;
    expT e;
    forever begin
      @(negedge clk_i);
      if (!rstn_i || !enable_i) begin
        active = 1'b0;
      end else begin
        if (active) begin
          idx++;
          if (pwm_o) begin
            hiCnt++;
            if (sawLow) badShape = 1'b1;
          end else begin
            sawLow = 1'b1;
          end
          if (period_strb_o || idx >= PERIOD) begin
            checkOutput("strobe_spacing", period_strb_o ? idx : 0, PERIOD);
            if (sbQ.size() == 0) begin
              checks++;
              errors++;
              $display("[TB] FAIL unexpected_period: duty %0d high %0d with nothing expected", dutySeen, hiCnt);
            end else begin
              e = sbQ.pop_front();
              checkOutput("period_duty", dutySeen, e.duty);
              checkOutput("period_high", hiCnt, e.high);
              checkOutput("period_shape", int'(badShape), 0);
            end
            active = 1'b0;
          end
        end
        if (period_strb_o) begin
          active   = 1'b1;
          idx      = 0;
          hiCnt    = 0;
          sawLow   = 1'b0;
          badShape = 1'b0;
          dutySeen = int'(duty_o);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : driver
    int maxPwm;

    waitCycles(3);
    checkOutput("reset_pwm", int'(pwm_o), 0);
    checkOutput("reset_strb", int'(period_strb_o), 0);
    checkOutput("reset_duty", int'(duty_o), 0);
    #1 rstn_i = 1'b1;
    waitCycles(4);
    checkOutput("idle_duty", int'(duty_o), 0);
    checkOutput("idle_strb", int'(period_strb_o), 0);

    // Directed periods: demand changes mid-period and must only land at the next boundary.
    applyStimulus(1'b1, pidTab[0]);
    pushExp(expTab[0]);
    waitStrobe("first_strobe");
    checkOutput("enable_duty", int'(duty_o), expTab[0]);
    for (int i = 1; i < NPER; i++) begin
      waitCycles(50);
      applyStimulus(1'b1, pidTab[i]);
      pushExp(expTab[i]);
      waitStrobe("period_strobe");
    end

    // Disable mid-period with the output high, then restart from a clean period.
    waitStrobe("pre_disable_strobe");
    waitCycles(10);
    checkOutput("pwm_before_disable", int'(pwm_o), 1);
    applyStimulus(1'b0, pidTab[NPER-1]);
    waitCycles(1);
    checkOutput("disable_pwm", int'(pwm_o), 0);
    checkOutput("disable_duty", int'(duty_o), 0);
    checkOutput("disable_strb", int'(period_strb_o), 0);
    maxPwm = 0;
    for (int i = 0; i < 4; i++) begin
      waitCycles(1);
      if (pwm_o || period_strb_o) maxPwm = 1;
    end
    checkOutput("disabled_quiet", maxPwm, 0);
    applyStimulus(1'b1, 60);
    pushExp(REENABLE_DUTY);
    waitCycles(1);
    checkOutput("reenable_strb", int'(period_strb_o), 1);
    checkOutput("reenable_duty", int'(duty_o), REENABLE_DUTY);
    waitStrobe("reenable_next_strobe");

    // Asynchronous reset while the output is high.
    waitCycles(5);
    checkOutput("pwm_before_reset", int'(pwm_o), 1);
    #2;
    rstn_i   = 1'b0;
    enable_i = 1'b0;
    #1;
    checkOutput("async_reset_pwm", int'(pwm_o), 0);
    checkOutput("async_reset_strb", int'(period_strb_o), 0);
    checkOutput("async_reset_duty", int'(duty_o), 0);
    waitCycles(3);
    #1 rstn_i = 1'b1;
    maxPwm = 0;
    for (int i = 0; i < 20; i++) begin
      waitCycles(1);
      if (pwm_o || period_strb_o || duty_o != '0) maxPwm = 1;
    end
    checkOutput("post_reset_quiet", maxPwm, 0);
    checkOutput("scoreboard_drained", sbQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
